booth2_final_adder: RTL and testbench

- Final carry-propagate stage of the 16x16 Booth-2/Wallace multiplier.
- Consumes the two 31-bit redundant partial products from the compressor tree and produces the 32-bit signed product.
- The addition is split into two pipelined halves, with a valid/ready handshake on both sides and a sideband tag carried alongside each result.
- Throughput is one result per cycle; latency is 2 cycles when the output is not stalled.

---
 rtl/booth2_final_adder.sv | 119 +++++++++++
 tb/tb_booth2_final_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/booth2_final_adder.sv
// booth2_final_adder: final carry-propagate adder of the 16x16 Booth-2/Wallace
// multiplier. It adds the two redundant partial products in two pipelined
// halves: the low LO_W bits first, then the upper bits plus the carry. Both
// sides use a valid/ready handshake, and a sideband tag travels with each
// operation.
module booth2_final_adder #(
    parameter int PP_W  = 31,
    parameter int LO_W  = 16,
    parameter int TAG_W = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PP_W-1:0]   in_pp1,
    input  logic [PP_W-1:0]   in_pp2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*LO_W-1:0] out_product,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int HI_W  = PP_W - LO_W;
    localparam int OUT_W = 2 * LO_W;

    // Stage 1: low-half sum and carry, upper operand slices, tag
    logic              s1_valid_q, s1_valid_d;
    logic [LO_W-1:0]   s1_lo_q,    s1_lo_d;
    logic              s1_c_q,     s1_c_d;
    logic [HI_W-1:0]   s1_hi1_q,   s1_hi1_d;
    logic [HI_W-1:0]   s1_hi2_q,   s1_hi2_d;
    logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;

    // Stage 2: complete PP_W-bit sum and tag
    logic              s2_valid_q, s2_valid_d;
    logic [PP_W-1:0]   s2_sum_q,   s2_sum_d;
    logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;

    logic              adv1_s;
    logic              adv2_s;
    logic [LO_W:0]     lo_sum_s;
    logic [HI_W-1:0]   hi_sum_s;

    // Flow control, both partial sums, and the next state of each stage
    always_comb begin
        adv2_s   = ~s2_valid_q | out_ready;
        adv1_s   = ~s1_valid_q | adv2_s;

        lo_sum_s = {1'b0, in_pp1[LO_W-1:0]} + {1'b0, in_pp2[LO_W-1:0]};
        // The carry out of the top bit is dropped by the HI_W-bit width
        hi_sum_s = s1_hi1_q + s1_hi2_q + HI_W'(s1_c_q);

        s1_valid_d = s1_valid_q;
        s1_lo_d    = s1_lo_q;
        s1_c_d     = s1_c_q;
        s1_hi1_d   = s1_hi1_q;
        s1_hi2_d   = s1_hi2_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_tag_d   = s2_tag_q;

        if (adv1_s) begin
            s1_valid_d = in_valid & in_ready;
            s1_lo_d    = lo_sum_s[LO_W-1:0];
            s1_c_d     = lo_sum_s[LO_W];
            s1_hi1_d   = in_pp1[PP_W-1:LO_W];
            s1_hi2_d   = in_pp2[PP_W-1:LO_W];
            s1_tag_d   = in_tag;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (adv2_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_d = {hi_sum_s, s1_lo_q};
                s2_tag_d = s1_tag_q;
            end else begin
                s2_sum_d = s2_sum_q;
                s2_tag_d = s2_tag_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Valid bits and output registers; reset clears the pipeline and zeroes the outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= {PP_W{1'b0}};
            s2_tag_q   <= {TAG_W{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    // Stage-1 data registers; contents are don't-care while s1_valid_q is low
    always_ff @(posedge sys_clk) begin
        s1_lo_q  <= s1_lo_d;
        s1_c_q   <= s1_c_d;
        s1_hi1_q <= s1_hi1_d;
        s1_hi2_q <= s1_hi2_d;
        s1_tag_q <= s1_tag_d;
    end

    // in_ready is held high in reset, but reset still refuses the transfer
    assign in_ready    = adv1_s | sys_rst;
    assign out_valid   = s2_valid_q & ~sys_rst;
    assign out_product = OUT_W'($signed(s2_sum_q));
    assign out_tag     = s2_tag_q;

endmodule

// File: tb/tb_booth2_final_adder.sv
// Directed bench for booth2_final_adder: reset state, arithmetic vectors,
// back-pressure, reset while entries are in flight, and a short randomised
// stream checked against a queue of reference results.
module tb_booth2_final_adder;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        in_valid;
    logic        in_ready;
    logic [30:0] in_pp1;
    logic [30:0] in_pp2;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_product;
    logic [3:0]  out_tag;

    int errors = 0;
    int checks = 0;

    booth2_final_adder dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pp1      (in_pp1),
        .in_pp2      (in_pp2),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_tag     (out_tag)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [30:0] a, input logic [30:0] b);
        logic [30:0] s;
        s = a + b;
        return {s[30], s};
    endfunction

    // Single operation with out_ready high: checks 2-cycle latency and a one-cycle pulse
    task automatic send_one(input string name, input logic [30:0] a, input logic [30:0] b,
                            input logic [3:0] t, input logic [31:0] exp_p);
        in_pp1 = a; in_pp2 = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk({name, "_lat1_valid"}, {35'd0, out_valid}, 36'd0);
        cyc();
        chk({name, "_valid"}, {35'd0, out_valid}, 36'd1);
        chk({name, "_prod"}, {4'd0, out_product}, {4'd0, exp_p});
        chk({name, "_tag"}, {32'd0, out_tag}, {32'd0, t});
        cyc();
        chk({name, "_pulse"}, {35'd0, out_valid}, 36'd0);
    endtask

    logic [35:0] exp_q[$];
    logic [35:0] e;
    logic        r0, r1;
    logic        vin;

    initial begin
        sys_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_pp1 = 31'd0; in_pp2 = 31'd0; in_tag = 4'd0;
        cyc(); cyc();
        chk("rst_out_valid", {35'd0, out_valid}, 36'd0);
        chk("rst_in_ready", {35'd0, in_ready}, 36'd1);
        chk("rst_out_product", {4'd0, out_product}, 36'd0);
        chk("rst_out_tag", {32'd0, out_tag}, 36'd0);
        sys_rst = 1'b0;

        // Arithmetic vectors
        send_one("basic", 31'h3, 31'h4, 4'd5, 32'h0000_0007);
        send_one("carry_split", 31'h0000_FFFF, 31'h1, 4'd6, 32'h0001_0000);
        send_one("wrap_neg2", 31'h7FFF_FFFF, 31'h7FFF_FFFF, 4'd7, 32'hFFFF_FFFE);
        send_one("min_neg", 31'h4000_0000, 31'h0, 4'd8, 32'hC000_0000);
        send_one("max_pos", 31'h3FFF_FFFF, 31'h0, 4'd9, 32'h3FFF_FFFF);

        // Back-pressure: tag k carries pp1=k*0x100, pp2=k*4, so the result is k*0x104
        in_valid = 1'b1; in_tag = 4'd1; in_pp1 = 31'h100; in_pp2 = 31'h4;
        cyc();
        in_tag = 4'd2; in_pp1 = 31'h200; in_pp2 = 31'h8; out_ready = 1'b0;
        #1;
        chk("bp_ready_one_full", {35'd0, in_ready}, 36'd1);
        cyc();
        in_tag = 4'd3; in_pp1 = 31'h300; in_pp2 = 31'hC;
        #1;
        chk("bp_ready_both_full", {35'd0, in_ready}, 36'd0);
        chk("bp_tag1_a", {32'd0, out_tag}, 36'd1);
        chk("bp_prod1_a", {4'd0, out_product}, 36'h104);
        cyc();
        chk("bp_ready_hold", {35'd0, in_ready}, 36'd0);
        chk("bp_tag1_b", {32'd0, out_tag}, 36'd1);
        chk("bp_prod1_b", {4'd0, out_product}, 36'h104);
        cyc();
        chk("bp_tag1_c", {32'd0, out_tag}, 36'd1);
        chk("bp_valid_held", {35'd0, out_valid}, 36'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", {35'd0, in_ready}, 36'd1);
        cyc();
        chk("bp_tag2", {32'd0, out_tag}, 36'd2);
        chk("bp_prod2", {4'd0, out_product}, 36'h208);
        in_tag = 4'd4; in_pp1 = 31'h400; in_pp2 = 31'h10;
        cyc();
        in_valid = 1'b0;
        chk("bp_tag3", {32'd0, out_tag}, 36'd3);
        chk("bp_valid3", {35'd0, out_valid}, 36'd1);
        chk("bp_prod3", {4'd0, out_product}, 36'h30C);
        cyc();
        chk("bp_tag4", {32'd0, out_tag}, 36'd4);
        chk("bp_prod4", {4'd0, out_product}, 36'h410);
        cyc();
        chk("bp_drained", {35'd0, out_valid}, 36'd0);

        // Reset with two entries in flight
        out_ready = 1'b0; in_valid = 1'b1;
        in_tag = 4'hA; in_pp1 = 31'h11; in_pp2 = 31'h20;
        cyc();
        in_tag = 4'hB; in_pp1 = 31'h22; in_pp2 = 31'h40;
        cyc();
        in_valid = 1'b0;
        chk("mid_full", {35'd0, in_ready}, 36'd0);
        sys_rst = 1'b1;
        cyc();
        sys_rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("mid_rst_valid", {35'd0, out_valid}, 36'd0);
        cyc();
        chk("mid_gone1", {35'd0, out_valid}, 36'd0);
        cyc();
        chk("mid_gone2", {35'd0, out_valid}, 36'd0);
        send_one("post_rst", 31'h1234, 31'h5678, 4'hC, 32'h0000_68AC);

        // Randomised stream with random in_valid/out_ready
        for (int i = 0; i < 400; i++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_pp1 = 31'($urandom);
            in_pp2 = 31'($urandom) & 31'h7FFF_FFFC;
            in_tag = 4'($urandom);
            vin = 1'($urandom_range(0, 1));
            in_valid = 1'b0;
            #1 r0 = in_ready;
            in_valid = 1'b1;
            #1 r1 = in_ready;
            in_valid = vin;
            #1;
            if (r0 !== r1) begin
                chk("stream_ready_indep", {35'd0, r1}, {35'd0, r0});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_spurious", {35'd0, out_valid}, 36'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_result", {out_tag, out_product}, e);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({in_tag, ref_prod(in_pp1, in_pp2)});
            end
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("drain_spurious", {35'd0, out_valid}, 36'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("drain_result", {out_tag, out_product}, e);
                end
            end
            cyc();
        end
        chk("stream_all_out", 36'(exp_q.size()), 36'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
